dcs_frame_ctrl: RTL and testbench

//  Sequencer for the DCS CRC+FEC datapath. Accepts a 32-bit payload word on a valid/ready port.

---
 rtl/dcs_frame_ctrl_if.sv | 21 ++
 rtl/dcs_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_dcs_frame_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcs_frame_ctrl_if.sv
// Valid/ready word stream used for the payload input and codeword output.
// The master drives valid and data; the slave drives ready.
interface dcs_frame_ctrl_if #(
    parameter int W = 32
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/dcs_frame_ctrl.sv
// Frame sequencer for the DCS CRC+FEC datapath: serialises a payload word,
// builds {payload, CRC}, waits for done and returns the codeword. Option: DCS_TIMEOUT_EN.
module dcs_frame_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CRC_W   = 16,
    parameter int FEC_W   = 96,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dcs_frame_ctrl_if.slave         in_if,
    dcs_frame_ctrl_if.master        out_if,
    output logic                    dcs_start,
    output logic                    dcs_d,
    output logic [DATA_W+CRC_W-1:0] dcs_fec_in,
    input  logic [CRC_W-1:0]        dcs_crc,
    input  logic                    dcs_done,
    input  logic [FEC_W-1:0]        dcs_result,
    output logic                    out_err,
    output logic [7:0]              frame_cnt
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        LOAD,
        WAIT,
        OUT
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  payload;
    logic [CNT_W-1:0]   bit_cnt;
    logic               out_valid;
    logic [FEC_W-1:0]   out_data;

`ifdef DCS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]    wait_cnt;
    logic               err_q;
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    assign in_if.ready  = (state == IDLE);
    assign out_if.valid = out_valid;
    assign out_if.data  = out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            payload    <= '0;
            bit_cnt    <= '0;
            dcs_start  <= 1'b0;
            dcs_d      <= 1'b0;
            dcs_fec_in <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_cnt  <= '0;
`ifdef DCS_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_if.valid) begin
                        shreg     <= in_if.data;
                        payload   <= in_if.data;
                        dcs_start <= 1'b1;
                        dcs_d     <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    // First serial bit is presented together with SHIFT entry
                    dcs_start <= 1'b0;
                    dcs_d     <= shreg[DATA_W-1];
                    shreg     <= {shreg[DATA_W-2:0], 1'b0};
                    bit_cnt   <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        dcs_d <= 1'b0;
                        state <= LOAD;
                    end else begin
                        dcs_d   <= shreg[DATA_W-1];
                        shreg   <= {shreg[DATA_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    dcs_fec_in <= {payload, dcs_crc};
                    state      <= WAIT;
`ifdef DCS_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                end
                WAIT: begin
                    if (dcs_done) begin
                        out_data  <= dcs_result;
                        out_valid <= 1'b1;
                        state     <= OUT;
`ifdef DCS_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        out_data  <= '0;
                        out_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= OUT;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                OUT: begin
                    if (out_if.ready) begin
                        out_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcs_frame_ctrl.sv
// Randomised frame bench for dcs_frame_ctrl with a small DCS responder
// and a frame-level model of the serial stream, fec_in, codeword and count.
module tb_dcs_frame_ctrl;

    localparam int DATA_W  = 32;
    localparam int CRC_W   = 16;
    localparam int FEC_W   = 96;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcs_frame_ctrl_if #(.W(DATA_W)) in_if ();
    dcs_frame_ctrl_if #(.W(FEC_W))  out_if ();

    logic                    dcs_start;
    logic                    dcs_d;
    logic [DATA_W+CRC_W-1:0] dcs_fec_in;
    logic [CRC_W-1:0]        dcs_crc;
    logic                    dcs_done;
    logic [FEC_W-1:0]        dcs_result;
    logic                    out_err;
    logic [7:0]              frame_cnt;

    dcs_frame_ctrl #(
        .DATA_W  (DATA_W),
        .CRC_W   (CRC_W),
        .FEC_W   (FEC_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (in_if),
        .out_if     (out_if),
        .dcs_start  (dcs_start),
        .dcs_d      (dcs_d),
        .dcs_fec_in (dcs_fec_in),
        .dcs_crc    (dcs_crc),
        .dcs_done   (dcs_done),
        .dcs_result (dcs_result),
        .out_err    (out_err),
        .frame_cnt  (frame_cnt)
    );

    int         total = 0;
    int         bad = 0;
    int         acc_cnt = 0;
    logic [7:0] exp_cnt = 8'd0;

    always @(posedge clk)
        if (in_if.valid && in_if.ready)
            acc_cnt <= acc_cnt + 1;

    task automatic chk(input string tag,
                       input logic [FEC_W-1:0] got,
                       input logic [FEC_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [FEC_W-1:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at the negedge after the handoff.
    task automatic run_frame(input logic [DATA_W-1:0] pl,
                             input logic [CRC_W-1:0]  crc,
                             input logic [FEC_W-1:0]  res,
                             input int                dly,
                             input int                rdly,
                             input bit                keep,
                             input bit                early);
        logic [DATA_W-1:0] bits;
        int                n_start;
        int                w;
        w = 0;
        while (in_if.ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("idle_wait", in_if.ready, 1);
        in_if.valid = 1'b1;
        in_if.data  = pl;
        dcs_crc     = crc;
        dcs_result  = rnd96();
        if (early) out_if.ready = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) in_if.valid = 1'b0;
        bits    = '0;
        n_start = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (keep) in_if.data = $urandom;
            n_start += int'(dcs_start);
            if (k == 1) chk("start_pulse", dcs_start, 1);
            if (k >= 2 && k <= 33) bits[33-k] = dcs_d;
            if (k == 5) chk("busy_ready", in_if.ready, 0);
            if (k == 20) chk("early_valid", out_if.valid, 0);
            if (k == 30) dcs_done = 1'b0;
        end
        chk("start_count", n_start, 1);
        chk("serial", bits, pl);
        chk("d_load", dcs_d, 0);
        @(negedge clk);
        chk("fec_in", dcs_fec_in, {pl, crc});
        dcs_crc = $urandom;
        repeat (dly) @(negedge clk);
        chk("no_valid", out_if.valid, 0);
        dcs_done   = 1'b1;
        dcs_result = res;
        @(negedge clk);
        chk("valid", out_if.valid, 1);
        chk("data", out_if.data, res);
        chk("err", out_err, 0);
        dcs_result = rnd96();
        if (!early) begin
            repeat (rdly) @(negedge clk);
            chk("hold_valid", out_if.valid, 1);
            chk("hold_data", out_if.data, res);
            out_if.ready = 1'b1;
        end
        @(negedge clk);
        out_if.ready = 1'b0;
        exp_cnt++;
        chk("frame_cnt", frame_cnt, exp_cnt);
        chk("drop_valid", out_if.valid, 0);
        chk("in_ready", in_if.ready, 1);
        chk("fec_hold", dcs_fec_in, {pl, crc});
    endtask

    initial begin
        int   a0;
        bit   seen;
        int   seen_k;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        dcs_crc      = '0;
        dcs_done     = 1'b0;
        dcs_result   = '0;

        repeat (3) @(negedge clk);
        chk("rst_start", dcs_start, 0);
        chk("rst_d", dcs_d, 0);
        chk("rst_fec", dcs_fec_in, 0);
        chk("rst_valid", out_if.valid, 0);
        chk("rst_data", out_if.data, 0);
        chk("rst_err", out_err, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_ready", in_if.ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(32'h03010203, 16'hA5C3,
                  96'h1234_5678_9ABC_DEF0_1357_9BDF,
                  3, 5, 1'b0, 1'b0);

        a0 = acc_cnt;
        run_frame($urandom, $urandom, rnd96(), 1, 0, 1'b1, 1'b0);
        run_frame($urandom, $urandom, rnd96(), 0, 2, 1'b1, 1'b0);
        run_frame($urandom, $urandom, rnd96(), 2, 1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("accepts", acc_cnt - a0, 3);
        chk("cnt_after3", frame_cnt, 4);

        // Abort a frame while shifting bit 10
        in_if.valid = 1'b1;
        in_if.data  = $urandom;
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_start", dcs_start, 0);
        chk("mid_d", dcs_d, 0);
        chk("mid_fec", dcs_fec_in, 0);
        chk("mid_valid", out_if.valid, 0);
        chk("mid_data", out_if.data, 0);
        chk("mid_cnt", frame_cnt, 0);
        chk("mid_ready", in_if.ready, 1);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 8'd0;
        @(negedge clk);
        run_frame(32'hFFFFFFFF, $urandom, rnd96(), 1, 1, 1'b0, 1'b0);

        for (int i = 0; i < 260; i++)
            run_frame($urandom, $urandom, rnd96(),
                      $urandom_range(0, 4), $urandom_range(0, 3),
                      1'b0, $urandom_range(0, 3) == 0);

        // Frame whose done never arrives
        dcs_done    = 1'b0;
        in_if.valid = 1'b1;
        in_if.data  = $urandom;
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        seen   = 1'b0;
        seen_k = 0;
        for (int k = 1; k <= 34 + TIMEOUT + 40; k++) begin
            @(negedge clk);
            if (!seen && out_if.valid === 1'b1) begin
                seen   = 1'b1;
                seen_k = k;
            end
        end
`ifdef DCS_TIMEOUT_EN
        chk("to_seen", seen, 1);
        chk("to_latency", seen_k, 35 + TIMEOUT);
        chk("to_err", out_err, 1);
        chk("to_data", out_if.data, 0);
        out_if.ready = 1'b1;
        @(negedge clk);
        out_if.ready = 1'b0;
        exp_cnt++;
        chk("to_cnt", frame_cnt, exp_cnt);
`else
        chk("no_timeout", seen, 0);
        chk("stuck_ready", in_if.ready, 0);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
